// File: rtl/dac_seq_pkg.sv
// Shared state encoding, error codes and helpers for the DAC run sequencer.
package dac_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_ADC,
    S_START_FIFO,
    S_GAP,
    S_START_DAC,
    S_WAIT_RUN,
    S_RUNNING,
    S_STOP,
    S_WAIT_STOP,
    S_ERROR
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE             = 2'd0,
    ERR_ADC_TIMEOUT      = 2'd1,
    ERR_RUN_ACK_TIMEOUT  = 2'd2,
    ERR_STOP_ACK_TIMEOUT = 2'd3
  } err_code_t;

  // States whose only job is to drive one command pulse for a single cycle.
  function automatic logic is_cmd_state(input seq_state_t s);
    return (s == S_START_FIFO) || (s == S_START_DAC) || (s == S_STOP);
  endfunction

endpackage

// File: rtl/cmd_spacing_timer.sv
// Saturating cycle counter: cleared synchronously, flags once LIMIT cycles have
// accumulated since the last clear. Optionally comes out of reset already expired.
module cmd_spacing_timer #(
  parameter int unsigned LIMIT     = 8,
  parameter bit          RESET_SAT = 1'b0
) (
  input  logic clk_125,
  input  logic reset_n,
  input  logic clear,
  output logic expired
);

  localparam int unsigned W   = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= RESET_SAT ? LIM : '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_q != LIM) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = (count_q == LIM);

endmodule

// File: rtl/dac_run_sequencer.sv
// Start/stop sequencer for the FIFO + DAC pair: paces command pulses globally,
// waits on status acknowledges with a timeout, and latches the failure cause.
module dac_run_sequencer
  import dac_seq_pkg::*;
#(
  parameter int unsigned PULSE_GAP   = 8,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic       clk_125,
  input  logic       reset_n,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       clear_err,
  input  logic       ADC_ready_125,
  input  logic       DAC_running_125,
  output logic       start_fifo_cmd_125,
  output logic       start_dac_cmd_125,
  output logic       stop_dac_cmd_125,
  output logic       busy,
  output logic       running,
  output logic       error,
  output logic [1:0] error_code
);

  seq_state_t state_q, state_d;
  err_code_t  err_q, err_d;
  logic       stop_pend_q, stop_pend_d;
  logic       err_pend_q, err_pend_d;
  logic       gap_ok, ack_expired, stop_seen;

  // Spacing restarts on the cycle a pulse is driven, so gap_ok rises exactly
  // when the following cycle may carry the next pulse.
  cmd_spacing_timer #(
    .LIMIT    (PULSE_GAP - 1),
    .RESET_SAT(1'b1)
  ) u_spacing (
    .clk_125(clk_125),
    .reset_n(reset_n),
    .clear  (is_cmd_state(state_d)),
    .expired(gap_ok)
  );

  cmd_spacing_timer #(
    .LIMIT    (ACK_TIMEOUT),
    .RESET_SAT(1'b0)
  ) u_ack_timeout (
    .clk_125(clk_125),
    .reset_n(reset_n),
    .clear  (state_d != state_q),
    .expired(ack_expired)
  );

  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      err_q       <= ERR_NONE;
      stop_pend_q <= 1'b0;
      err_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
      err_pend_q  <= err_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    stop_pend_d = stop_pend_q;
    err_pend_d  = err_pend_q;
    stop_seen   = stop_req || stop_pend_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_req && !stop_req)
          state_d = (ADC_ready_125 && gap_ok) ? S_START_FIFO : S_WAIT_ADC;
      end
      S_WAIT_ADC: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else if (ADC_ready_125 && gap_ok) begin
          state_d = S_START_FIFO;
        end else if (ack_expired) begin
          state_d = S_ERROR;
          err_d   = ERR_ADC_TIMEOUT;
        end
      end
      S_START_FIFO: begin
        if (stop_req) stop_pend_d = 1'b1;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (stop_req) stop_pend_d = 1'b1;
        if (gap_ok) state_d = S_START_DAC;
      end
      S_START_DAC: begin
        if (stop_req) stop_pend_d = 1'b1;
        state_d = S_WAIT_RUN;
      end
      S_WAIT_RUN: begin
        if (stop_seen) begin
          stop_pend_d = 1'b1;
          if (gap_ok) state_d = S_STOP;
        end else if (DAC_running_125) begin
          state_d = S_RUNNING;
        end else if (ack_expired) begin
          err_pend_d = 1'b1;
          err_d      = ERR_RUN_ACK_TIMEOUT;
          if (gap_ok) state_d = S_STOP;
        end
      end
      S_RUNNING: begin
        if (!DAC_running_125) begin
          state_d = S_IDLE;
        end else if (stop_seen) begin
          stop_pend_d = 1'b1;
          if (gap_ok) state_d = S_STOP;
        end
      end
      S_STOP: state_d = S_WAIT_STOP;
      S_WAIT_STOP: begin
        if (!DAC_running_125) begin
          state_d = err_pend_q ? S_ERROR : S_IDLE;
        end else if (ack_expired) begin
          state_d = S_ERROR;
          err_d   = ERR_STOP_ACK_TIMEOUT;
        end
      end
      S_ERROR: begin
        if (clear_err) begin
          state_d    = S_IDLE;
          err_d      = ERR_NONE;
          err_pend_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_STOP || state_d == S_IDLE) stop_pend_d = 1'b0;
  end

  assign start_fifo_cmd_125 = (state_q == S_START_FIFO);
  assign start_dac_cmd_125  = (state_q == S_START_DAC);
  assign stop_dac_cmd_125   = (state_q == S_STOP);
  assign running            = (state_q == S_RUNNING);
  assign error              = (state_q == S_ERROR);
  assign busy               = !((state_q == S_IDLE) || (state_q == S_RUNNING) || (state_q == S_ERROR));
  assign error_code         = err_q;

endmodule
